// File: rtl/powlib_sfifo.sv
// rtl/powlib_sfifo.sv - single-clock first-word-fall-through FIFO with valid/ready on both sides
module powlib_sfifo #(
    parameter int W   = 16,
    parameter int D   = 8,
    parameter int AFT = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [W-1:0]         wrdata,
    input  logic                 wrvld,
    output logic                 wrrdy,
    output logic                 wrafull,
    output logic [W-1:0]         rddata,
    output logic                 rdvld,
    input  logic                 rdrdy,
    output logic [$clog2(D):0]   cnt
);

    localparam int AW = $clog2(D);
    localparam int PW = AW + 1;

    localparam logic [PW-1:0] FULL_CNT = PW'(D);
    localparam logic [PW-1:0] AFULL_TH = PW'(AFT);
    localparam logic [PW-1:0] ONE      = PW'(1);

    logic [W-1:0]  mem_q [D];

    // Pointers carry one extra MSB so full and empty stay distinguishable.
    logic [PW-1:0] wrptr_q, wrptr_d;
    logic [PW-1:0] rdptr_q, rdptr_d;
    logic [PW-1:0] cnt_q,   cnt_d;

    logic          wr_en;
    logic          rd_en;

    // Status flags come only from registered state, never from wrvld/rdrdy.
    always_comb begin
        rdvld   = (cnt_q != '0);
        wrrdy   = (cnt_q != FULL_CNT) && !rst;
        wrafull = (cnt_q >= AFULL_TH);
        cnt     = cnt_q;
        rddata  = mem_q[rdptr_q[AW-1:0]];
    end

    // Handshake qualification: a refused write or an empty read is a no-op.
    always_comb begin
        wr_en = wrvld && wrrdy;
        rd_en = rdvld && rdrdy;
    end

    // Next-state for pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_comb begin
        wrptr_d = wrptr_q;
        rdptr_d = rdptr_q;
        cnt_d   = cnt_q;
        if (wr_en) begin
            wrptr_d = wrptr_q + ONE;
        end
        if (rd_en) begin
            rdptr_d = rdptr_q + ONE;
        end
        unique case ({wr_en, rd_en})
            2'b10:   cnt_d = cnt_q + ONE;
            2'b01:   cnt_d = cnt_q - ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and count registers; reset drops every stored word at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrptr_q <= '0;
            rdptr_q <= '0;
            cnt_q   <= '0;
        end else begin
            wrptr_q <= wrptr_d;
            rdptr_q <= rdptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage array is not reset; wrrdy is low during reset so no write lands then.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wrptr_q[AW-1:0]] <= wrdata;
        end
    end

endmodule
